// File: rtl/activation_serializer.sv
// activation_serializer
// Requantizes non-negative ReLU accumulator words to ACT_W-bit activations,
// buffers them in a small word FIFO and shifts them out LSB-first on a
// ready/valid bit-serial port. The upstream side is never stalled; words that
// arrive while the FIFO is full (and nothing is popped) are dropped and
// recorded in the sticky overflow flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no word in the shift register, ser_valid low
// ST_SHIFT | presenting shreg[0] on ser_bit, advancing on each transfer
module activation_serializer #(
    parameter int ACC_W      = 40,
    parameter int ACT_W      = 8,
    parameter int SHIFT      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [ACC_W-1:0]       in_data,
    input  logic                          in_valid,
    output logic                          ser_bit,
    output logic                          ser_valid,
    output logic                          ser_first,
    output logic                          ser_last,
    input  logic                          ser_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(ACT_W);
    localparam int RW = ACC_W + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(ACT_W - 1);
    localparam logic [BW-1:0] PENULT   = BW'(ACT_W - 2);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t             state;
    logic [ACT_W-1:0]   shreg;
    logic [BW-1:0]      bit_cnt;

    logic [RW-1:0]      pos_ext;
    logic [RW-1:0]      rounded;
    logic [ACT_W-1:0]   act_val;

    logic [ACT_W-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [ACT_W-1:0]   head;

    logic               fifo_nonempty;
    logic               word_done;
    logic               pop;
    logic               push;
    logic               drop;
    logic               shift_nxt;
    logic [CW-1:0]      count_nxt;
    logic               busy_nxt;

    // Clamp negatives to zero; the extra top bit keeps the rounding add from wrapping.
    always_comb begin
        pos_ext = '0;
        if (!in_data[ACC_W-1]) begin
            pos_ext = {1'b0, in_data};
        end
    end

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
            logic [RW-1:0] biased;
            // Round half up, then drop the fractional bits.
            always_comb begin
                biased  = pos_ext + HALF;
                rounded = biased >> SHIFT;
            end
        end else begin : g_noround
            // No fractional bits to remove.
            always_comb begin
                rounded = pos_ext;
            end
        end
    endgenerate

    // Saturate anything that does not fit in ACT_W bits to all ones.
    always_comb begin
        act_val = rounded[ACT_W-1:0];
        if (|rounded[RW-1:ACT_W]) begin
            act_val = '1;
        end
    end

    // Push/pop decisions; a pop frees the slot a same-edge push needs when full.
    always_comb begin
        head          = mem[rd_ptr];
        fifo_nonempty = (fifo_count != '0);
        word_done     = (state == ST_SHIFT) && ser_ready && (bit_cnt == LAST_BIT);
        pop           = fifo_nonempty && ((state == ST_IDLE) || word_done);
        push          = in_valid && ((fifo_count != FULL_CNT) || pop);
        drop          = in_valid && !push;
        shift_nxt     = pop || ((state == ST_SHIFT) && !word_done);
        count_nxt     = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = fifo_count - CW'(1);
        end
        busy_nxt = shift_nxt || (count_nxt != '0);
    end

    // FIFO storage; contents are don't-care until written, so no reset needed.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= act_val;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= count_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
            busy <= busy_nxt;
        end
    end

    // Serializer FSM with registered serial outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state     <= ST_SHIFT;
                        shreg     <= head;
                        bit_cnt   <= '0;
                        ser_bit   <= head[0];
                        ser_valid <= 1'b1;
                        ser_first <= 1'b1;
                        ser_last  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        if (bit_cnt != LAST_BIT) begin
                            shreg     <= shreg >> 1;
                            ser_bit   <= shreg[1];
                            bit_cnt   <= bit_cnt + BW'(1);
                            ser_first <= 1'b0;
                            ser_last  <= (bit_cnt == PENULT);
                        end else if (pop) begin
                            // Back-to-back word: load without an idle bubble.
                            shreg     <= head;
                            bit_cnt   <= '0;
                            ser_bit   <= head[0];
                            ser_first <= 1'b1;
                            ser_last  <= 1'b0;
                        end else begin
                            state     <= ST_IDLE;
                            ser_bit   <= 1'b0;
                            ser_valid <= 1'b0;
                            ser_first <= 1'b0;
                            ser_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    ser_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_activation_serializer.sv
// Directed bench for activation_serializer with default parameters.
module tb_activation_serializer;

    localparam int ACC_W = 40;
    localparam int ACT_W = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic signed [ACC_W-1:0] in_data;
    logic                    in_valid;
    logic                    ser_bit;
    logic                    ser_valid;
    logic                    ser_first;
    logic                    ser_last;
    logic                    ser_ready;
    logic [2:0]              fifo_count;
    logic                    overflow;
    logic                    busy;

    int n_assert = 0;
    int n_fail   = 0;

    activation_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .ser_first  (ser_first),
        .ser_last   (ser_last),
        .ser_ready  (ser_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [ACC_W-1:0] din;
        logic [ACT_W-1:0]        exp;
        string                   name;
    } vec_t;

    vec_t vecs[11];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One word through an idle pipe with ser_ready high: latency, framing, value.
    task automatic run_vec(input vec_t v);
        logic [ACT_W-1:0] got;
        got      = '0;
        in_data  = v.din;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk({v.name, "_cnt_after_push"}, fifo_count, 1);
        chk({v.name, "_valid_after_push"}, ser_valid, 0);
        chk({v.name, "_busy_after_push"}, busy, 1);
        tick;
        chk({v.name, "_cnt_after_load"}, fifo_count, 0);
        for (int i = 0; i < ACT_W; i++) begin
            chk({v.name, "_valid"}, ser_valid, 1);
            chk({v.name, "_first"}, ser_first, (i == 0));
            chk({v.name, "_last"}, ser_last, (i == ACT_W - 1));
            got[i] = ser_bit;
            tick;
        end
        chk({v.name, "_value"}, got, v.exp);
        chk({v.name, "_idle_after"}, ser_valid, 0);
        chk({v.name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, 0 expected");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ACC_W-1:0]        burst [6];
        logic [63:0]             rx;
        logic [15:0]             b2b;
        logic [ACT_W-1:0]        bp_got;
        int                      nbits;
        int                      nx;
        logic                    rdy;
        logic                    prev_stall;
        logic                    pb, pf, pl;
        logic                    hit;

        vecs[0]  = '{40'sh180,          8'h02, "round_0x180"};
        vecs[1]  = '{40'sh17F,          8'h01, "round_0x17F"};
        vecs[2]  = '{40'sh10000,        8'hFF, "clamp_0x10000"};
        vecs[3]  = '{-40'sd1,           8'h00, "clamp_neg1"};
        vecs[4]  = '{40'sh7FFFFFFFFF,   8'hFF, "clamp_maxpos"};
        vecs[5]  = '{40'sh0,            8'h00, "zero"};
        vecs[6]  = '{40'sh7F,           8'h00, "round_0x7F"};
        vecs[7]  = '{40'sh80,           8'h01, "round_0x80"};
        vecs[8]  = '{40'shFF7F,         8'hFF, "round_0xFF7F"};
        vecs[9]  = '{40'shFF80,         8'hFF, "sat_0xFF80"};
        vecs[10] = '{40'sh5A80,         8'h5B, "round_0x5A80"};

        burst[0] = 40'h1100;
        burst[1] = 40'h2200;
        burst[2] = 40'h3300;
        burst[3] = 40'h4400;
        burst[4] = 40'h5500;
        burst[5] = 40'h6600;

        // Reset held with in_valid asserted: nothing may be pushed.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 40'sh5500;
        ser_ready = 1'b1;
        repeat (3) tick;
        chk("rst_ser_bit", ser_bit, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ser_first", ser_first, 0);
        chk("rst_ser_last", ser_last, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick;
        chk("rel_fifo_count", fifo_count, 0);
        chk("rel_ser_valid", ser_valid, 0);
        chk("rel_busy", busy, 0);
        tick;
        chk("rel_ser_valid_2", ser_valid, 0);

        // Requantization table.
        for (int k = 0; k < 11; k++) begin
            run_vec(vecs[k]);
            tick;
        end

        // Backpressure: random ready, outputs must hold while stalled.
        in_data    = 40'shA500;
        in_valid   = 1'b1;
        ser_ready  = 1'b0;
        tick;
        in_valid   = 1'b0;
        nx         = 0;
        prev_stall = 1'b0;
        pb = 1'b0; pf = 1'b0; pl = 1'b0;
        bp_got     = '0;
        for (int c = 0; c < 200 && nx < ACT_W; c++) begin
            if (prev_stall) begin
                chk("bp_hold_valid", ser_valid, 1);
                chk("bp_hold_bit", ser_bit, pb);
                chk("bp_hold_first", ser_first, pf);
                chk("bp_hold_last", ser_last, pl);
            end
            rdy       = 1'($urandom_range(0, 1));
            ser_ready = rdy;
            if (ser_valid) begin
                if (rdy) begin
                    chk("bp_first", ser_first, (nx == 0));
                    chk("bp_last", ser_last, (nx == ACT_W - 1));
                    bp_got[nx[2:0]] = ser_bit;
                    nx++;
                end
                prev_stall = !rdy;
                pb = ser_bit;
                pf = ser_first;
                pl = ser_last;
            end else begin
                prev_stall = 1'b0;
            end
            tick;
        end
        chk("bp_transfers", nx, ACT_W);
        chk("bp_value", bp_got, 8'hA5);
        chk("bp_idle_after", ser_valid, 0);
        ser_ready = 1'b1;
        tick;
        chk("bp_no_extra", ser_valid, 0);

        // Back-to-back words: no bubble between ser_last and next ser_first.
        in_data  = 40'sh100;
        in_valid = 1'b1;
        tick;
        in_data  = 40'sh200;
        tick;
        in_valid = 1'b0;
        b2b      = '0;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_valid", ser_valid, 1);
            chk("b2b_first", ser_first, ((i % 8) == 0));
            chk("b2b_last", ser_last, ((i % 8) == 7));
            b2b[i] = ser_bit;
            tick;
        end
        chk("b2b_word1", b2b[7:0], 8'h01);
        chk("b2b_word2", b2b[15:8], 8'h02);
        chk("b2b_idle_after", ser_valid, 0);
        tick;

        // Six-word burst: sixth word dropped, first five serialized in order.
        rx    = '0;
        nbits = 0;
        for (int c = 0; c < 70; c++) begin
            if (c < 6) begin
                in_valid = 1'b1;
                in_data  = burst[c];
            end else begin
                in_valid = 1'b0;
            end
            if (ser_valid && ser_ready && nbits < 64) begin
                chk("burst_first", ser_first, ((nbits % 8) == 0));
                chk("burst_last", ser_last, ((nbits % 8) == 7));
                rx[nbits] = ser_bit;
                nbits++;
            end
            tick;
            if (c == 4) begin
                chk("burst_ovf_before_6th", overflow, 0);
                chk("burst_cnt_full", fifo_count, 4);
            end
            if (c == 5) begin
                chk("burst_ovf_on_6th", overflow, 1);
                chk("burst_cnt_after_drop", fifo_count, 4);
            end
        end
        chk("burst_nbits", nbits, 40);
        chk("burst_w1", rx[7:0], 8'h11);
        chk("burst_w2", rx[15:8], 8'h22);
        chk("burst_w3", rx[23:16], 8'h33);
        chk("burst_w4", rx[31:24], 8'h44);
        chk("burst_w5", rx[39:32], 8'h55);
        chk("burst_idle", ser_valid, 0);
        chk("burst_ovf_sticky", overflow, 1);
        chk("burst_cnt_end", fifo_count, 0);
        chk("burst_busy_end", busy, 0);

        // Reset clears overflow; then overflow again and abort mid-word.
        rst_n = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        chk("rst2_overflow", overflow, 0);
        tick;
        nbits = 0;
        hit   = 1'b0;
        for (int c = 0; c < 70 && !hit; c++) begin
            if (c < 6) begin
                in_valid = 1'b1;
                in_data  = burst[c];
            end else begin
                in_valid = 1'b0;
            end
            if (ser_valid && nbits == 11) begin
                chk("mid_ovf_before_rst", overflow, 1);
                chk("mid_not_first", ser_first, 0);
                rst_n    = 1'b0;
                in_valid = 1'b0;
                tick;
                hit = 1'b1;
                chk("mid_rst_valid", ser_valid, 0);
                chk("mid_rst_last", ser_last, 0);
                chk("mid_rst_cnt", fifo_count, 0);
                chk("mid_rst_ovf", overflow, 0);
                chk("mid_rst_busy", busy, 0);
            end else begin
                if (ser_valid && ser_ready) begin
                    nbits++;
                end
                tick;
            end
        end
        chk("mid_reset_point_reached", hit, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("post_rst_valid", ser_valid, 0);
            chk("post_rst_last", ser_last, 0);
            chk("post_rst_cnt", fifo_count, 0);
        end
        run_vec('{40'sh3C00, 8'h3C, "post_rst_word"});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/activation_serializer.md
# activation_serializer

Requantizes the non-negative accumulator words produced by the ReLU activation stage and converts them into an LSB-first bit-serial stream for the next layer's bit-serial MAC array. Sits directly downstream of `relu_activation` and accepts its `in_data`/`in_valid` output with no backpressure toward it. A small FIFO absorbs bursts. A shift-register FSM drives a ready/valid serial port.

## Interface
- `ACC_W`, default 40: accumulator/ReLU word width, signed.
- `ACT_W`, default 8: unsigned activation width emitted serially; must be ≥ 2.
- `SHIFT`, default 8: requantization right-shift; 0 allowed; must be < ACC_W.
- `FIFO_DEPTH`, default 4: word FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  ACC_W  signed word from ReLU stage.
- `in_valid`  in  1  in_data qualifier; sampled every edge, never stalled.
- `ser_bit`  out  1  current serial activation bit.
- `ser_valid`  out  1  ser_bit valid.
- `ser_first`  out  1  ser_bit is bit 0 of a word.
- `ser_last`  out  1  ser_bit is bit ACT_W-1 of a word.
- `ser_ready`  in  1  downstream accepts bit; transfer = ser_valid & ser_ready.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words currently in FIFO, excluding the word in the shift register.
- `overflow`  out  1  sticky; a word was dropped.
- `busy`  out  1  FSM in SHIFT or FIFO non-empty.

## Operation
- Requantize on FIFO write:
  - Negative in_data is forced to 0.
  - If SHIFT>0: r = (in_data + 2^(SHIFT-1)) >> SHIFT, round-half-up, computed in ACC_W+1 bits so there is no wrap. If SHIFT=0: r = in_data.
  - If r > 2^ACT_W-1, saturate to 2^ACT_W-1.
  - The FIFO stores ACT_W-bit values.
- FIFO push on in_valid:
  - If count < FIFO_DEPTH, push.
  - If count == FIFO_DEPTH and no pop occurs this edge, drop the word and set `overflow` (cleared only by reset).
  - If a pop and a push occur on the same edge while full, the push is accepted and count is unchanged.
- FSM states:
  - IDLE:
    - ser_valid = 0.
    - If FIFO is non-empty: pop head into shift register, bit_cnt = 0, go to SHIFT.
  - SHIFT:
    - ser_valid = 1, ser_bit = shreg[0], ser_first = (bit_cnt==0), ser_last = (bit_cnt==ACT_W-1).
    - On transfer with bit_cnt < ACT_W-1: shift right, bit_cnt+1.
    - On transfer with bit_cnt == ACT_W-1 and FIFO non-empty: pop and load the next word, bit_cnt = 0, stay in SHIFT. There is no bubble between words.
    - On transfer with bit_cnt == ACT_W-1 and FIFO empty: go to IDLE.
- With ser_valid high and ser_ready low, ser_bit, ser_first and ser_last hold stable. No bit is ever skipped or repeated.
- Reset mid-word: the partial word and FIFO contents are discarded. No ser_last is emitted for the aborted word.

## Timing
- Reset values: ser_bit=0, ser_valid=0, ser_first=0, ser_last=0, fifo_count=0, overflow=0, busy=0, state IDLE.
- Latency:
  - in_valid sampled at edge E0 → fifo_count=1 after E0.
  - Loaded at E1 → ser_valid=1 with bit 0 and ser_first=1 after E1.
  - Net: 2 edges.
- Throughput with ser_ready held high: one word per ACT_W cycles. A back-to-back ReLU burst of more than FIFO_DEPTH+1 words overflows when FIFO_DEPTH+1 < ACT_W.
- ser_* outputs are registered. fifo_count, overflow and busy are registered and update on the same edge as the causing event.

## Test plan
- Reset:
  - Assert rst_n=0 for 3 cycles with in_valid=1 → all outputs 0, no pushes.
  - Release → idle, fifo_count=0.
- Rounding (defaults, ser_ready=1):
  - in_data=0x180 → value 2; bits 0,1,0,0,0,0,0,0; ser_first on cycle 1, ser_last on cycle 8.
  - in_data=0x17F → value 1.
- Clamp:
  - in_data=0x10000 → 0xFF, all ones.
  - in_data=-1 → 0x00.
  - in_data=max positive → 0xFF, no wrap.
- Backpressure: word 0xA5 (in_data=0xA500) with ser_ready pseudo-random at ~50% → bit sequence 1,0,1,0,0,1,0,1 exact; outputs stable while stalled; exactly 8 transfers.
- Back-to-back: two words 0x100 and 0x200 pushed on consecutive cycles → the ser_last transfer of word 1 is immediately followed, next cycle, by ser_first of word 2 with ser_valid continuously high for 16 cycles.
- Overflow and reset mid-word:
  - Drive a 6-word consecutive burst → words 1-5 serialized, word 6 dropped, overflow=1 from the 6th push edge.
  - Then assert reset at bit 3 of word 2 → ser_valid=0 after the reset edge, fifo_count=0, overflow=0.
